// File: rtl/food_spawner_pkg.sv
// Shared snake-game constants, FSM encoding and the saturating BCD score increment.
package food_spawner_pkg;

    localparam int          X_MAX_D  = 160;
    localparam int          Y_MAX_D  = 120;
    localparam int          XW       = 8;
    localparam int          YW       = 7;
    localparam logic [2:0]  FOOD_COL = 3'b100;
    localparam logic [2:0]  BLACK    = 3'b000;
    localparam logic [15:0] SEED_D   = 16'hACE1;

    typedef enum logic [1:0] {
        S_PICK = 2'd0,
        S_DRAW = 2'd1,
        S_WAIT = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    // Three-digit BCD +1 that sticks at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        logic [3:0] d0, d1, d2;
        d0 = s[3:0];
        d1 = s[7:4];
        d2 = s[11:8];
        if (s == 12'h999) return s;
        if (d0 != 4'd9) return {d2, d1, d0 + 4'd1};
        if (d1 != 4'd9) return {d2, d1 + 4'd1, 4'd0};
        return {d2 + 4'd1, 4'd0, 4'd0};
    endfunction

endpackage

// File: rtl/food_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running out of reset.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) q <= seed;
        else      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/food_spawner.sv
// Places food on random legal cells, draws it via the shared plot mux,
// and turns head-on-food steps into a grow pulse plus a BCD score bump.
module food_spawner
    import food_spawner_pkg::*;
#(
    parameter int          X_MAX       = X_MAX_D,
    parameter int          Y_MAX       = Y_MAX_D,
    parameter int          BORDER      = 1,
    parameter logic [2:0]  FOOD_COLOUR = FOOD_COL,
    parameter logic [15:0] SEED        = SEED_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [XW-1:0] head_x,
    input  logic [YW-1:0] head_y,
    input  logic          is_dead,
    input  logic          plot_gnt,
    output logic          plot_req,
    output logic          plot_en,
    output logic [XW-1:0] plot_x,
    output logic [YW-1:0] plot_y,
    output logic [2:0]    plot_colour,
    output logic [XW-1:0] food_x,
    output logic [YW-1:0] food_y,
    output logic          food_valid,
    output logic          grow,
    output logic [11:0]   score
);

    localparam logic [XW-1:0] X_LO = XW'(BORDER);
    localparam logic [XW-1:0] X_HI = XW'(X_MAX - 1 - BORDER);
    localparam logic [YW-1:0] Y_LO = YW'(BORDER);
    localparam logic [YW-1:0] Y_HI = YW'(Y_MAX - 1 - BORDER);

    state_t        r_state, w_next;
    logic [15:0]   w_lfsr;
    logic [XW-1:0] w_cx, r_food_x, r_plot_x, w_fx_nxt;
    logic [YW-1:0] w_cy, r_food_y, r_plot_y, w_fy_nxt;
    logic [2:0]    r_plot_colour;
    logic [11:0]   r_score;
    logic          w_cand_ok, w_eat, w_drawn, r_plot_req, r_food_valid, r_grow;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (w_lfsr)
    );

    assign w_cx = w_lfsr[7:0];
    assign w_cy = w_lfsr[14:8];

    assign w_cand_ok = (w_cx >= X_LO) && (w_cx <= X_HI) &&
                       (w_cy >= Y_LO) && (w_cy <= Y_HI) &&
                       ({w_cx, w_cy} != {head_x, head_y});

    // Death masks every same-cycle event: eat, grant and placement.
    assign w_eat   = (r_state == S_WAIT) && go && !is_dead &&
                     ({head_x, head_y} == {r_food_x, r_food_y});
    assign w_drawn = (r_state == S_DRAW) && plot_gnt && !is_dead;

    always_comb begin
        w_next = r_state;
        if (is_dead) begin
            w_next = S_DEAD;
        end else begin
            case (r_state)
                S_PICK:  if (w_cand_ok) w_next = S_DRAW;
                S_DRAW:  if (plot_gnt)  w_next = S_WAIT;
                S_WAIT:  if (w_eat)     w_next = S_PICK;
                default: w_next = S_DEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_PICK;
        else      r_state <= w_next;
    end

    // Plot outputs are registered from next state, so they line up with S_DRAW.
    assign w_fx_nxt = (r_state == S_PICK) ? w_cx : r_food_x;
    assign w_fy_nxt = (r_state == S_PICK) ? w_cy : r_food_y;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_food_x      <= '0;
            r_food_y      <= '0;
            r_food_valid  <= 1'b0;
            r_grow        <= 1'b0;
            r_score       <= '0;
            r_plot_req    <= 1'b0;
            r_plot_x      <= '0;
            r_plot_y      <= '0;
            r_plot_colour <= BLACK;
        end else begin
            r_grow <= w_eat;
            if (r_state == S_PICK && w_next == S_DRAW) begin
                r_food_x <= w_cx;
                r_food_y <= w_cy;
            end
            if (w_drawn)    r_food_valid <= 1'b1;
            else if (w_eat) r_food_valid <= 1'b0;
            if (w_eat) r_score <= bcd_inc(r_score);
            r_plot_req    <= (w_next == S_DRAW);
            r_plot_x      <= (w_next == S_DRAW) ? w_fx_nxt : '0;
            r_plot_y      <= (w_next == S_DRAW) ? w_fy_nxt : '0;
            r_plot_colour <= (w_next == S_DRAW) ? FOOD_COLOUR : BLACK;
        end
    end

    assign plot_en     = r_plot_req & plot_gnt & ~is_dead;
    assign plot_req    = r_plot_req;
    assign plot_x      = r_plot_x;
    assign plot_y      = r_plot_y;
    assign plot_colour = r_plot_colour;
    assign food_x      = r_food_x;
    assign food_y      = r_food_y;
    assign food_valid  = r_food_valid;
    assign grow        = r_grow;
    assign score       = r_score;

endmodule
